// File: rtl/spm_pkg.sv
// Shared constants and state encoding for the serial-parallel multiplier
// product path.
package spm_pkg;

    localparam int SPM_PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spm_state_e;

endpackage

// File: rtl/spm_bit_counter.sv
// Terminal-count bit counter: counts 0..TC-1, holds at TC-1 instead of
// wrapping, and raises o_last while sitting on the terminal value.
module spm_bit_counter #(
    parameter int TC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    localparam int CW = (TC > 1) ? $clog2(TC) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(TC - 1));
    assign o_last = w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_last) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spm_product_collector.sv
// Deserialises the LSB-first product stream of the SPM into a parallel word
// and hands it off with a valid/ready handshake.
module spm_product_collector
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_PROD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_bit,
    output logic             busy,
    output logic [WIDTH-1:0] product,
    output logic             prod_valid,
    input  logic             prod_ready
);

    spm_state_e       r_state;
    spm_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_cnt_last;
    logic             w_shift_en;

    spm_bit_counter #(
        .TC (WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_last (w_cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Acceptance edges never sample ser_bit: only SHIFT enables the shifter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                w_cnt_en   = 1'b1;
                if (w_cnt_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (prod_ready) begin
                    if (start) begin
                        w_state_nxt = SHIFT;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Right shift with insertion at the MSB leaves the first bit at bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sreg <= '0;
        end else if (w_shift_en) begin
            r_sreg <= {ser_bit, r_sreg[WIDTH-1:1]};
        end
    end

    assign busy       = (r_state == SHIFT);
    assign prod_valid = (r_state == DONE);
    assign product    = r_sreg;

endmodule

// File: tb/tb_spm_product_collector.sv
// Scoreboard bench: captures push expected products, a negedge monitor
// pops and compares on every handshake.
module tb_spm_product_collector;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ser_bit;
    logic        busy;
    logic [15:0] product;
    logic        prod_valid;
    logic        prod_ready;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb_q[$];

    spm_product_collector #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ser_bit    (ser_bit),
        .busy       (busy),
        .product    (product),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && prod_valid === 1'b1 && prod_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_xfer", {16'h0, product}, 32'hDEAD_BEEF);
            end else begin
                chk("sb_product", {16'h0, product}, {16'h0, sb_q.pop_front()});
            end
        end
    end

    // One full capture; leaves the bench just after the edge that enters DONE.
    task automatic send(input logic [15:0] v, input int ign_at);
        start   = 1'b1;
        ser_bit = 1'b0;
        sb_q.push_back(v);
        @(posedge clk); #2;
        start = 1'b0;
        chk("accept_busy", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            ser_bit = v[i];
            start   = (i == ign_at);
            @(posedge clk); #2;
            start = 1'b0;
            if (i < 15) chk("busy_shift", {31'h0, busy}, 32'h1);
        end
        chk("latency_valid", {31'h0, prod_valid}, 32'h1);
        chk("done_busy", {31'h0, busy}, 32'h0);
    endtask

    task automatic idle_check(input string nm);
        @(posedge clk); #2;
        chk(nm, {30'h0, busy, prod_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        ser_bit    = 1'b0;
        prod_ready = 1'b1;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_valid", {31'h0, prod_valid}, 32'h0);
        chk("rst_product", {16'h0, product}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // -3*5, consumer always ready: valid for exactly one cycle
        send(16'hFFF1, -1);
        idle_check("one_cycle_valid");

        // 6*6 with backpressure
        prod_ready = 1'b0;
        send(16'h0024, -1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'h0, prod_valid}, 32'h1);
            chk("bp_product", {16'h0, product}, 32'h0024);
            @(posedge clk); #2;
        end
        chk("bp_still_valid", {31'h0, prod_valid}, 32'h1);
        prod_ready = 1'b1;
        idle_check("bp_to_idle");

        // stray start at bit 7 is ignored
        send(16'h7FFF, 7);
        idle_check("ign_to_idle");

        // back-to-back: next start lands on the transfer edge
        send(16'h0024, -1);
        send(16'h4000, -1);
        idle_check("b2b_to_idle");

        // async reset in the middle of a capture
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ser_bit = 1'b1;
            @(posedge clk); #2;
        end
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_valid", {31'h0, prod_valid}, 32'h0);
        chk("midrst_product", {16'h0, product}, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        send(16'h0001, -1);
        idle_check("post_rst_idle");

        chk("sb_empty", sb_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spm_product_collector.md
SPM_PRODUCT_COLLECTOR -- requirements
Module: spm_product_collector

Interface
REQ-001 Parameter WIDTH, default 16, is the product width in bits (2 x 8 for the signed 8x8 SPM).
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  is the reset: asynchronous, active-low; rst=0 SHALL reset the block immediately, independent of clk.
REQ-004 start  input  1  is a one-cycle request to begin capturing one serial product.
REQ-005 ser_bit  input  1  is the serial product bit from the carry-save adder chain, LSB first, one bit per cycle.
REQ-006 busy  output  1  is high while bits are being captured (state SHIFT).
REQ-007 product  output  WIDTH  is the captured two's-complement product, stable while prod_valid=1.
REQ-008 prod_valid  output  1  signals that product holds a complete result.
REQ-009 prod_ready  input  1  is the consumer acceptance; a transfer occurs on any edge where prod_valid=1 and prod_ready=1.

Function
REQ-010 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-011 IDLE: start=1 SHALL move to SHIFT and clear the bit counter; ser_bit SHALL NOT be sampled on the acceptance edge.
REQ-012 SHIFT: each edge SHALL shift the register right and insert ser_bit at bit WIDTH-1, so that after WIDTH samples the first bit received is at bit 0.
REQ-013 SHIFT SHALL sample exactly WIDTH bits on the WIDTH edges that follow acceptance; the edge that samples bit WIDTH-1 SHALL enter DONE.
REQ-014 Latency: with start accepted at edge 0, prod_valid SHALL be high after edge WIDTH, with no bubbles.
REQ-015 DONE: prod_valid=1 and product SHALL hold until a transfer; after a transfer the block SHALL enter IDLE, or SHIFT if start=1 on the same edge (back-to-back capture).
REQ-016 start SHALL be ignored in SHIFT, and in DONE without prod_ready; no error is flagged and the capture in progress is unaffected.
REQ-017 The bit counter SHALL be $clog2(WIDTH) bits wide, count 0..WIDTH-1 and never wrap while in SHIFT.
REQ-018 busy SHALL equal (state==SHIFT); prod_valid SHALL equal (state==DONE); both are registered-state decodes with no combinational path from the inputs.
REQ-019 product SHALL be driven directly from the shift register; its contents are don't-care outside DONE.

Reset
REQ-020 rst=0 SHALL force the state to IDLE, the counter to 0 and the shift register to 0; busy=0, prod_valid=0 and product=0.
REQ-021 Reset mid-SHIFT or in DONE SHALL discard the partial or pending product; no transfer occurs.
REQ-022 After rst deasserts, the first start SHALL be honoured on the first rising edge on which it is high.

Structure
REQ-023 Shared package spm_pkg SHALL hold the constant SPM_PROD_W=16 and the state enum {IDLE, SHIFT, DONE}; WIDTH defaults to SPM_PROD_W.
REQ-024 One sub-module, spm_bit_counter (terminal-count counter with clear/enable and a last flag), is natural; the shift register and FSM SHALL stay in the top module.

Verification
REQ-025 -3*5: start, then ser_bit = bits of 0xFFF1 LSB first (1,0,0,0,1,1,...,1) with prod_ready=1 -> prod_valid high after edge 16 for 1 cycle, product=0xFFF1.
REQ-026 Backpressure: product 0x0024 (6*6) with prod_ready=0 for 5 cycles -> prod_valid and product held at 0x0024 unchanged; transfer on the first ready cycle; then IDLE.
REQ-027 Ignored start: pulse start at bit 7 of a capture of 0x7FFF -> capture completes on schedule, product=0x7FFF, busy never drops.
REQ-028 Back-to-back: in DONE, start=1 and prod_ready=1 on the same edge -> next product (0x4000, -128*-128) valid exactly 16 edges later with no IDLE cycle.
REQ-029 Reset mid-operation: drive rst=0 asynchronously at bit 9 -> outputs are 0 immediately; after release, a new capture of 0x0001 completes correctly.
